// File: rtl/m_extcall_stream_controller.sv
// Executes termcalls and hypercalls from the ternary core: streams a header, register
// arguments or a RAM-resident tryte string on the master stream, and takes getc replies.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for i_enable; call fields latched on acceptance
// HDR      | header beat {type, code} pending on the master stream
// ARG      | putc register beats r1..rN pending, one per handshake
// RX       | getc: waiting for a reply beat on the slave stream
// RAM_REQ  | log: first cycle of a tryte read request
// RAM_WAIT | log: read request held until the memory reports ready
// DATA     | log: payload tryte beat pending
// TAIL     | log: terminating zero beat pending
// DONE     | one-cycle completion pulse with fault / exit flags
module m_extcall_stream_controller #(
    parameter int N_REGS      = 4,
    parameter int TRYTE_W     = 18,
    parameter int AXIS_W      = 32,
    parameter int PACKET_MODE = 0,
    parameter int LOG_MAX     = 64
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_enable,
    input  logic                        i_type,
    input  logic [5:0]                  i_code,
    input  logic [N_REGS*TRYTE_W-1:0]   i_regs,
    output logic [AXIS_W-1:0]           o_m_axis_tdata,
    output logic                        o_m_axis_tlast,
    input  logic                        i_m_axis_tready,
    output logic                        o_m_axis_tvalid,
    input  logic [AXIS_W-1:0]           i_s_axis_tdata,
    input  logic                        i_s_axis_tvalid,
    output logic                        o_s_axis_tready,
    output logic                        o_ram_enable,
    output logic                        o_ram_write,
    output logic [1:0]                  o_ram_pt,
    output logic [TRYTE_W-1:0]          o_ram_addr,
    input  logic                        i_ram_ready,
    input  logic                        i_ram_pagefault,
    input  logic [TRYTE_W-1:0]          i_ram_out,
    output logic [TRYTE_W-1:0]          o_result,
    output logic                        o_ready,
    output logic                        o_pagefault,
    output logic                        o_exit
);

    localparam int IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam int CNT_W = $clog2(LOG_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_ARG,
        S_RX,
        S_RAM_REQ,
        S_RAM_WAIT,
        S_DATA,
        S_TAIL,
        S_DONE
    } state_t;

    state_t                      state;
    state_t                      state_next;

    logic                        call_type;
    logic [5:0]                  call_code;
    logic [N_REGS*TRYTE_W-1:0]   regs_q;
    logic [IDX_W-1:0]            arg_idx;
    logic [TRYTE_W-1:0]          addr_q;
    logic [TRYTE_W-1:0]          data_q;
    logic [CNT_W-1:0]            log_cnt;
    logic                        fault_q;
    logic [TRYTE_W-1:0]          result_q;

    logic                        load_call;
    logic                        arg_step;
    logic                        rx_take;
    logic                        rd_take;
    logic                        rd_fault;

    logic                        is_putc;
    logic                        is_getc;
    logic                        is_log;
    logic                        last_arg;
    logic                        log_full;
    logic [TRYTE_W-1:0]          cur_arg;
    logic [AXIS_W-1:0]           hdr_word;

    // Balanced-ternary +1, trit 0 in the low bit pair; +1 rolls over to -1 with carry.
    function automatic logic [TRYTE_W-1:0] tern_inc(input logic [TRYTE_W-1:0] v);
        logic [TRYTE_W-1:0] r;
        logic               carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < TRYTE_W / 2; i++) begin
            if (carry) begin
                case (v[2*i +: 2])
                    2'b00: begin
                        r[2*i +: 2] = 2'b01;
                        carry       = 1'b0;
                    end
                    2'b11: begin
                        r[2*i +: 2] = 2'b00;
                        carry       = 1'b0;
                    end
                    default: r[2*i +: 2] = 2'b11;
                endcase
            end
        end
        return r;
    endfunction

    assign is_putc  = !call_type && (call_code == 6'd0);
    assign is_getc  = !call_type && (call_code == 6'd1);
    assign is_log   = call_type && (call_code == 6'd1);
    assign last_arg = (arg_idx == IDX_W'(N_REGS - 1));
    assign log_full = (log_cnt == CNT_W'(LOG_MAX));
    assign cur_arg  = regs_q[arg_idx*TRYTE_W +: TRYTE_W];
    assign hdr_word = {{(AXIS_W-7){1'b0}}, call_type, call_code};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        o_m_axis_tvalid = 1'b0;
        o_m_axis_tdata  = '0;
        o_m_axis_tlast  = 1'b0;
        o_s_axis_tready = 1'b0;
        o_ram_enable    = 1'b0;
        o_ready         = 1'b0;
        o_pagefault     = 1'b0;
        o_exit          = 1'b0;
        load_call       = 1'b0;
        arg_step        = 1'b0;
        rx_take         = 1'b0;
        rd_take         = 1'b0;
        rd_fault        = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_enable) begin
                    load_call  = 1'b1;
                    state_next = S_HDR;
                end
            end
            S_HDR: begin
                o_m_axis_tvalid = 1'b1;
                o_m_axis_tdata  = hdr_word;
                o_m_axis_tlast  = (PACKET_MODE == 0) || !(is_putc || is_log);
                if (i_m_axis_tready) begin
                    if (is_putc) begin
                        state_next = S_ARG;
                    end else if (is_getc) begin
                        state_next = S_RX;
                    end else if (is_log) begin
                        state_next = S_RAM_REQ;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_ARG: begin
                o_m_axis_tvalid = 1'b1;
                o_m_axis_tdata  = AXIS_W'(cur_arg);
                o_m_axis_tlast  = (PACKET_MODE == 0) || last_arg;
                if (i_m_axis_tready) begin
                    if (last_arg) begin
                        state_next = S_DONE;
                    end else begin
                        arg_step = 1'b1;
                    end
                end
            end
            S_RX: begin
                o_s_axis_tready = 1'b1;
                if (i_s_axis_tvalid) begin
                    rx_take    = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_RAM_REQ, S_RAM_WAIT: begin
                o_ram_enable = 1'b1;
                if (i_ram_ready) begin
                    if (i_ram_pagefault) begin
                        rd_fault   = 1'b1;
                        state_next = S_DONE;
                    end else if ((i_ram_out == '0) || log_full) begin
                        state_next = S_TAIL;
                    end else begin
                        rd_take    = 1'b1;
                        state_next = S_DATA;
                    end
                end else begin
                    state_next = S_RAM_WAIT;
                end
            end
            S_DATA: begin
                o_m_axis_tvalid = 1'b1;
                o_m_axis_tdata  = AXIS_W'(data_q);
                o_m_axis_tlast  = (PACKET_MODE == 0);
                if (i_m_axis_tready) begin
                    state_next = S_RAM_REQ;
                end
            end
            S_TAIL: begin
                o_m_axis_tvalid = 1'b1;
                o_m_axis_tlast  = 1'b1;
                if (i_m_axis_tready) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                o_ready     = 1'b1;
                o_pagefault = fault_q;
                o_exit      = call_type && (call_code == 6'd0);
                state_next  = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            call_type <= 1'b0;
            call_code <= '0;
            regs_q    <= '0;
            arg_idx   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            log_cnt   <= '0;
            fault_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            if (load_call) begin
                call_type <= i_type;
                call_code <= i_code;
                regs_q    <= i_regs;
                arg_idx   <= '0;
                addr_q    <= i_regs[TRYTE_W-1:0];
                log_cnt   <= '0;
                fault_q   <= 1'b0;
            end
            if (arg_step) begin
                arg_idx <= arg_idx + 1'b1;
            end
            if (rx_take) begin
                result_q <= i_s_axis_tdata[TRYTE_W-1:0];
            end
            if (rd_fault) begin
                fault_q <= 1'b1;
            end
            // The address only advances once the tryte is accepted as payload.
            if (rd_take) begin
                data_q  <= i_ram_out;
                addr_q  <= tern_inc(addr_q);
                log_cnt <= log_cnt + 1'b1;
            end
        end
    end

    generate
        if (AXIS_W > TRYTE_W) begin : g_reply_upper
            logic unused_reply_bits;
            assign unused_reply_bits = ^i_s_axis_tdata[AXIS_W-1:TRYTE_W];
        end
    endgenerate

    assign o_ram_write = 1'b0;
    assign o_ram_pt    = 2'b01;
    assign o_ram_addr  = addr_q;
    assign o_result    = result_q;

endmodule

// File: tb/tb_m_extcall_stream_controller.sv
// Directed bench for m_extcall_stream_controller: one instance per packet mode, driven
// in lockstep, with a latency-programmable RAM responder and a gap-pattern sink.
module tb_m_extcall_stream_controller;

    localparam int N_REGS  = 4;
    localparam int TRYTE_W = 18;
    localparam int AXIS_W  = 32;

    localparam logic [TRYTE_W-1:0] ADDR_TBL [10] = '{18'h0, 18'h1, 18'h7, 18'h4, 18'h5,
                                                    18'h1F, 18'h1C, 18'h1D, 18'h13, 18'h10};
    localparam logic [TRYTE_W-1:0] DATA_TBL [10] = '{18'h3, 18'h1, 18'h4, 18'h1F, 18'h1D,
                                                    18'h10, 18'h17, 18'h15, 18'h7C, 18'h0};
    localparam int LAT_TBL [10] = '{0, 3, 7, 1, 5, 2, 6, 4, 0, 7};
    localparam int GAP_TBL [7]  = '{0, 3, 1, 5, 2, 0, 4};

    logic                        i_clk = 1'b0;
    logic                        i_rst_n;
    logic                        i_enable;
    logic                        i_type;
    logic [5:0]                  i_code;
    logic [N_REGS*TRYTE_W-1:0]   i_regs;
    logic                        i_m_axis_tready;
    logic [AXIS_W-1:0]           i_s_axis_tdata;
    logic                        i_s_axis_tvalid;
    logic                        i_ram_ready;
    logic                        i_ram_pagefault;
    logic [TRYTE_W-1:0]          i_ram_out;

    logic [AXIS_W-1:0]           tdata     [2];
    logic                        tlast     [2];
    logic                        tvalid    [2];
    logic                        s_tready  [2];
    logic                        ram_en    [2];
    logic                        ram_wr    [2];
    logic [1:0]                  ram_pt    [2];
    logic [TRYTE_W-1:0]          ram_addr  [2];
    logic [TRYTE_W-1:0]          result    [2];
    logic                        ready     [2];
    logic                        pagefault [2];
    logic                        exit_f    [2];

    int n_checks = 0;
    int n_errs   = 0;

    logic [AXIS_W:0] beats_a [$];
    logic [AXIS_W:0] beats_b [$];
    logic [AXIS_W:0] exp_b   [$];
    int  base_a, base_b;
    int  rdy_cnt [2];
    logic hs_seen;
    logic gap_mode;
    logic ready_level;
    int  n_reads;
    int  ram_base;
    int  fault_at;

    always #5 i_clk = ~i_clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        m_extcall_stream_controller #(
            .N_REGS(N_REGS), .TRYTE_W(TRYTE_W), .AXIS_W(AXIS_W),
            .PACKET_MODE(g), .LOG_MAX(64)
        ) dut (
            .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_type(i_type),
            .i_code(i_code), .i_regs(i_regs),
            .o_m_axis_tdata(tdata[g]), .o_m_axis_tlast(tlast[g]),
            .i_m_axis_tready(i_m_axis_tready), .o_m_axis_tvalid(tvalid[g]),
            .i_s_axis_tdata(i_s_axis_tdata), .i_s_axis_tvalid(i_s_axis_tvalid),
            .o_s_axis_tready(s_tready[g]),
            .o_ram_enable(ram_en[g]), .o_ram_write(ram_wr[g]), .o_ram_pt(ram_pt[g]),
            .o_ram_addr(ram_addr[g]), .i_ram_ready(i_ram_ready),
            .i_ram_pagefault(i_ram_pagefault), .i_ram_out(i_ram_out),
            .o_result(result[g]), .o_ready(ready[g]), .o_pagefault(pagefault[g]),
            .o_exit(exit_f[g])
        );
    end

    task automatic chk(input string tag, input logic [AXIS_W-1:0] got,
                       input logic [AXIS_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Beat monitor: records accepted beats and checks that a pending beat stays put.
    initial begin
        logic [AXIS_W-1:0] prev_data [2];
        logic              prev_last [2];
        logic              prev_pend [2];
        rdy_cnt   = '{0, 0};
        hs_seen   = 1'b0;
        prev_pend = '{1'b0, 1'b0};
        forever begin
            @(negedge i_clk);
            hs_seen = 1'b0;
            for (int d = 0; d < 2; d++) begin
                if (!i_rst_n) begin
                    prev_pend[d] = 1'b0;
                end else begin
                    if (prev_pend[d]) begin
                        chk($sformatf("stall_valid_%0d", d), tvalid[d], 1);
                        chk($sformatf("stall_data_%0d", d), tdata[d], prev_data[d]);
                        chk($sformatf("stall_last_%0d", d), tlast[d], prev_last[d]);
                    end
                    if (tvalid[d] && i_m_axis_tready) begin
                        if (d == 0) beats_a.push_back({tlast[d], tdata[d]});
                        else begin
                            beats_b.push_back({tlast[d], tdata[d]});
                            hs_seen = 1'b1;
                        end
                    end
                    prev_pend[d] = tvalid[d] && !i_m_axis_tready;
                    prev_data[d] = tdata[d];
                    prev_last[d] = tlast[d];
                    if (ready[d]) rdy_cnt[d]++;
                end
            end
        end
    end

    // Sink ready: either a fixed level or a gap pattern restarted after every handshake.
    initial begin
        int gap_left = 0;
        int gap_i    = 0;
        i_m_axis_tready = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            if (gap_mode) begin
                if (hs_seen) begin
                    gap_left = GAP_TBL[gap_i];
                    gap_i    = (gap_i + 1) % 7;
                end
                if (gap_left > 0) begin
                    i_m_axis_tready = 1'b0;
                    gap_left--;
                end else begin
                    i_m_axis_tready = 1'b1;
                end
            end else begin
                i_m_axis_tready = ready_level;
            end
        end
    end

    // RAM responder: read k answers after LAT_TBL[k] extra cycles with DATA_TBL[k].
    initial begin
        int  k;
        logic aborted;
        n_reads         = 0;
        i_ram_ready     = 1'b0;
        i_ram_pagefault = 1'b0;
        i_ram_out       = '0;
        forever begin
            @(negedge i_clk);
            if (i_rst_n && ram_en[1]) begin
                k = n_reads - ram_base;
                if (k > 9) begin
                    chk("ram_read_count", k, 9);
                    k = 9;
                end
                chk($sformatf("ram_addr_b%0d", k), ram_addr[1], ADDR_TBL[k]);
                chk($sformatf("ram_addr_a%0d", k), ram_addr[0], ADDR_TBL[k]);
                chk("ram_pt", ram_pt[1], 2'b01);
                chk("ram_write", ram_wr[1], 0);
                aborted = 1'b0;
                for (int c = 0; c < LAT_TBL[k]; c++) begin
                    @(negedge i_clk);
                    if (!i_rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    chk("ram_en_hold", ram_en[1], 1);
                    chk("ram_addr_hold", ram_addr[1], ADDR_TBL[k]);
                end
                if (!aborted) begin
                    i_ram_ready     = 1'b1;
                    i_ram_pagefault = (k == fault_at);
                    i_ram_out       = DATA_TBL[k];
                    @(posedge i_clk);
                    #1;
                    i_ram_ready     = 1'b0;
                    i_ram_pagefault = 1'b0;
                    i_ram_out       = '0;
                    n_reads++;
                    @(negedge i_clk);
                    if (i_rst_n) chk("ram_en_drop", ram_en[1], 0);
                end
            end
        end
    end

    task automatic begin_call();
        base_a = beats_a.size();
        base_b = beats_b.size();
        exp_b.delete();
    endtask

    task automatic exp_beat(input logic last, input logic [AXIS_W-1:0] d);
        exp_b.push_back({last, d});
    endtask

    // Called at posedge+1; the call is accepted on the next rising edge.
    task automatic start_call(input logic t, input logic [5:0] c,
                              input logic [N_REGS*TRYTE_W-1:0] r);
        i_enable = 1'b1;
        i_type   = t;
        i_code   = c;
        i_regs   = r;
        @(posedge i_clk);
        #1;
        i_enable = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget,
                             input logic exp_pf, input logic exp_ex);
        int n = 0;
        forever begin
            @(negedge i_clk);
            if (ready[1]) break;
            n++;
            if (n >= budget) begin
                chk({tag, "_timeout"}, 0, 1);
                break;
            end
        end
        chk({tag, "_ready_a"}, ready[0], 1);
        chk({tag, "_pf_a"}, pagefault[0], exp_pf);
        chk({tag, "_pf_b"}, pagefault[1], exp_pf);
        chk({tag, "_exit_a"}, exit_f[0], exp_ex);
        chk({tag, "_exit_b"}, exit_f[1], exp_ex);
        @(negedge i_clk);
        chk({tag, "_ready_pulse"}, ready[1], 0);
    endtask

    task automatic compare_beats(input string tag);
        chk({tag, "_cnt_a"}, beats_a.size() - base_a, exp_b.size());
        chk({tag, "_cnt_b"}, beats_b.size() - base_b, exp_b.size());
        for (int i = 0; i < exp_b.size(); i++) begin
            if (base_a + i < beats_a.size()) begin
                chk($sformatf("%s_data_a%0d", tag, i), beats_a[base_a+i][AXIS_W-1:0],
                    exp_b[i][AXIS_W-1:0]);
                chk($sformatf("%s_last_a%0d", tag, i), beats_a[base_a+i][AXIS_W], 1);
            end
            if (base_b + i < beats_b.size()) begin
                chk($sformatf("%s_data_b%0d", tag, i), beats_b[base_b+i][AXIS_W-1:0],
                    exp_b[i][AXIS_W-1:0]);
                chk($sformatf("%s_last_b%0d", tag, i), beats_b[base_b+i][AXIS_W],
                    exp_b[i][AXIS_W]);
            end
        end
    endtask

    task automatic check_quiet(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_tvalid%0d", tag, d), tvalid[d], 0);
            chk($sformatf("%s_tdata%0d", tag, d), tdata[d], 0);
            chk($sformatf("%s_tlast%0d", tag, d), tlast[d], 0);
            chk($sformatf("%s_stready%0d", tag, d), s_tready[d], 0);
            chk($sformatf("%s_ramen%0d", tag, d), ram_en[d], 0);
            chk($sformatf("%s_ramaddr%0d", tag, d), ram_addr[d], 0);
            chk($sformatf("%s_result%0d", tag, d), result[d], 0);
            chk($sformatf("%s_ready%0d", tag, d), ready[d], 0);
            chk($sformatf("%s_pf%0d", tag, d), pagefault[d], 0);
            chk($sformatf("%s_exit%0d", tag, d), exit_f[d], 0);
        end
    endtask

    initial begin
        int n;
        int rdy_snap;
        i_rst_n         = 1'b0;
        i_enable        = 1'b0;
        i_type          = 1'b0;
        i_code          = '0;
        i_regs          = '0;
        i_s_axis_tdata  = '0;
        i_s_axis_tvalid = 1'b0;
        gap_mode        = 1'b0;
        ready_level     = 1'b1;
        ram_base        = 0;
        fault_at        = 99;
        base_a          = 0;
        base_b          = 0;

        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check_quiet("reset");

        // Beep issued together with reset release: must be taken on the first edge.
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        begin_call();
        exp_beat(1'b1, 32'h3);
        start_call(1'b0, 6'd3, '0);
        @(negedge i_clk);
        chk("first_edge_accept", tvalid[1], 1);
        wait_done("beep", 50, 1'b0, 1'b0);
        compare_beats("beep");

        // Beep with the sink stalled for nine cycles.
        ready_level = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        begin_call();
        exp_beat(1'b1, 32'h3);
        start_call(1'b0, 6'd3, '0);
        for (int i = 0; i < 9; i++) begin
            @(negedge i_clk);
            chk($sformatf("stall_no_ready%0d", i), ready[1], 0);
            chk($sformatf("stall_hdr%0d", i), tdata[1], 32'h3);
        end
        ready_level = 1'b1;
        wait_done("beep_stall", 50, 1'b0, 1'b0);
        compare_beats("beep_stall");

        // Putc: header then r1..r4, top register all ones to check zero extension.
        @(posedge i_clk);
        #1;
        begin_call();
        exp_beat(1'b0, 32'h0);
        exp_beat(1'b0, 32'h0001_0011);
        exp_beat(1'b0, 32'h0000_0013);
        exp_beat(1'b0, 32'h0001_0111);
        exp_beat(1'b1, 32'h0003_FFFF);
        start_call(1'b0, 6'd0, {18'h3FFFF, 18'h10111, 18'h00013, 18'h10011});
        wait_done("putc", 100, 1'b0, 1'b0);
        compare_beats("putc");

        // Log from address 0 with RAM latencies 1..8 and sink gaps 0..5.
        @(posedge i_clk);
        #1;
        gap_mode = 1'b1;
        ram_base = n_reads;
        fault_at = 99;
        begin_call();
        exp_beat(1'b0, 32'h41);
        for (int i = 0; i < 9; i++) exp_beat(1'b0, AXIS_W'(DATA_TBL[i]));
        exp_beat(1'b1, 32'h0);
        start_call(1'b1, 6'd1, '0);
        wait_done("log", 600, 1'b0, 1'b0);
        compare_beats("log");
        chk("log_reads", n_reads - ram_base, 10);
        gap_mode = 1'b0;
        repeat (3) @(posedge i_clk);

        // Log faulting on the third read: two payload beats, no tail.
        #1;
        ram_base = n_reads;
        fault_at = 2;
        begin_call();
        exp_beat(1'b0, 32'h41);
        exp_beat(1'b0, AXIS_W'(DATA_TBL[0]));
        exp_beat(1'b0, AXIS_W'(DATA_TBL[1]));
        start_call(1'b1, 6'd1, '0);
        wait_done("log_fault", 300, 1'b1, 1'b0);
        compare_beats("log_fault");
        fault_at = 99;

        // Exit hypercall.
        @(posedge i_clk);
        #1;
        begin_call();
        exp_beat(1'b1, 32'h40);
        start_call(1'b1, 6'd0, '0);
        wait_done("exit", 50, 1'b0, 1'b1);
        compare_beats("exit");
        chk("result_before_getc", result[1], 0);

        // Getc: reply arrives four cycles after the header; upper reply bits ignored.
        @(posedge i_clk);
        #1;
        begin_call();
        exp_beat(1'b1, 32'h1);
        start_call(1'b0, 6'd1, '0);
        n = 0;
        while (beats_b.size() == base_b && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        chk("getc_hdr_seen", n < 50, 1);
        @(negedge i_clk);
        chk("getc_stready_a", s_tready[0], 1);
        chk("getc_stready_b", s_tready[1], 1);
        repeat (3) @(posedge i_clk);
        #1;
        i_s_axis_tdata  = 32'hFFFC_002A;
        i_s_axis_tvalid = 1'b1;
        @(posedge i_clk);
        #1;
        i_s_axis_tvalid = 1'b0;
        i_s_axis_tdata  = '0;
        wait_done("getc", 50, 1'b0, 1'b0);
        compare_beats("getc");
        chk("getc_result_a", result[0], 32'h2A);
        chk("getc_result_b", result[1], 32'h2A);

        // Result holds across an unrelated call.
        @(posedge i_clk);
        #1;
        begin_call();
        exp_beat(1'b1, 32'h3);
        start_call(1'b0, 6'd3, '0);
        wait_done("beep2", 50, 1'b0, 1'b0);
        compare_beats("beep2");
        chk("result_hold", result[1], 32'h2A);

        // Reset in the middle of a log: outputs clear at once, no completion pulse.
        @(posedge i_clk);
        #1;
        ram_base = n_reads;
        begin_call();
        start_call(1'b1, 6'd1, '0);
        n = 0;
        while (beats_b.size() < base_b + 4 && n < 300) begin
            @(negedge i_clk);
            n++;
        end
        chk("rst_log_progress", n < 300, 1);
        @(posedge i_clk);
        #1;
        rdy_snap = rdy_cnt[1];
        i_rst_n  = 1'b0;
        #1;
        check_quiet("rst_mid");
        repeat (12) @(posedge i_clk);
        chk("rst_no_ready", rdy_cnt[1], rdy_snap);

        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        begin_call();
        exp_beat(1'b1, 32'h3);
        start_call(1'b0, 6'd3, '0);
        @(negedge i_clk);
        chk("rst_release_accept", tvalid[1], 1);
        wait_done("beep3", 50, 1'b0, 1'b0);
        compare_beats("beep3");

        repeat (2) @(posedge i_clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
